// File: rtl/bcd_display_scanner.sv
// BCD display scanner: latches packed BCD digits on load and multiplexes
// them onto a common-anode 7-segment display with registered outputs.
module bcd_display_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    clear,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dpl_q, dpl_d;
  logic                    valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic       zero_above;
  logic [3:0] cur_dig;
  logic       cur_blank;
  logic       cur_dp;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    dig_d   = dig_q;
    dpl_d   = dpl_q;
    valid_d = valid_q;
    if (clear) begin
      dig_d   = '0;
      dpl_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      dig_d   = bcd_in;
      dpl_d   = dp_in;
      valid_d = 1'b1;
    end
  end

  // Walk from the top digit down so zero_above covers digit i and all above.
  always_comb begin
    zero_above = 1'b1;
    cur_dig    = '0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (dig_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_dig   = dig_q[4*i +: 4];
        cur_blank = (BLANK_LEADING != 0) && (i > 0) && zero_above;
        cur_dp    = dpl_q[i];
      end
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (valid_q) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = cur_blank ? 7'b1111111 : decode(cur_dig);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      dpl_q   <= '0;
      valid_q <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dpl_q   <= dpl_d;
      valid_q <= valid_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: cycle-count reference model,
// two instances (leading-zero blanking on and off) sharing one stimulus.
module tb_bcd_display_scanner;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic         clk = 1'b0;
  logic         reset, load, clear;
  logic [15:0]  bcd_in;
  logic [3:0]   dp_in;
  logic [6:0]   seg, seg_nb;
  logic         dp, dp_nb;
  logic [3:0]   an, an_nb;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .clear(clear),
    .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an)
  );

  bcd_display_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_LEADING(0)
  ) dut_nb (
    .clk(clk), .reset(reset), .load(load), .clear(clear),
    .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg_nb), .dp(dp_nb), .an(an_nb)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nb;
    logic       dp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: cycles since reset plus the latched value.
  int          m_cnt   = 0;
  logic [15:0] m_val   = '0;
  logic [3:0]  m_dp    = '0;
  bit          m_valid = 1'b0;

  function automatic logic [6:0] seg_of(int d);
    if (d < 10) return TAB[d];
    return DASH;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int   i;
    int   d;
    e.an = 4'b1111;
    e.seg = BLANK;
    e.seg_nb = BLANK;
    e.dp = 1'b1;
    if (!reset && m_valid) begin
      i = (m_cnt / RD) % N;
      d = int'((m_val >> (4 * i)) & 16'hF);
      e.an = ~(4'b0001 << i);
      e.seg_nb = seg_of(d);
      e.seg = (i > 0 && (m_val >> (4 * i)) == 16'h0) ? BLANK : seg_of(d);
      e.dp = ~m_dp[i];
    end
    return e;
  endfunction

  task automatic step();
    sbq.push_back(expect_now());
    if (reset) begin
      m_cnt = 0;
      m_val = '0;
      m_dp = '0;
      m_valid = 1'b0;
    end else begin
      m_cnt++;
      if (clear) begin
        m_val = '0;
        m_dp = '0;
        m_valid = 1'b0;
      end else if (load) begin
        m_val = bcd_in;
        m_dp = dp_in;
        m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d);
    load = 1'b1;
    bcd_in = v;
    dp_in = d;
    step();
    load = 1'b0;
  endtask

  task automatic wait_idx(int want);
    for (int k = 0; k < 4 * N * RD; k++) begin
      if ((m_cnt / RD) % N == want && m_cnt % RD == 0) break;
      step();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_cmp++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
          n_bad++;
          $display("FAIL blank_on t=%0t an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                   $time, an, seg, dp, e.an, e.seg, e.dp);
        end
        n_cmp++;
        if (an_nb !== e.an || seg_nb !== e.seg_nb || dp_nb !== e.dp) begin
          n_bad++;
          $display("FAIL blank_off t=%0t an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                   $time, an_nb, seg_nb, dp_nb, e.an, e.seg_nb, e.dp);
        end
      end
    end
  end

  initial begin : driver
    int r;
    reset = 1'b1;
    load = 1'b0;
    clear = 1'b0;
    bcd_in = '0;
    dp_in = '0;
    run(2);
    do_load(16'h1234, 4'hF);
    reset = 1'b0;
    run(6);

    do_load(16'h0257, 4'h0);
    run(2 * N * RD);
    do_load(16'h0000, 4'h0);
    run(N * RD + 2);
    do_load(16'h1A23, 4'b0100);
    run(N * RD + 2);

    wait_idx(1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    run(3);
    do_load(16'h0009, 4'h0);
    run(N * RD + 2);

    for (int k = 0; k < RD; k++) begin
      if (m_cnt % RD == RD - 1) break;
      step();
    end
    do_load(16'h4567, 4'b1010);
    run(N * RD);

    clear = 1'b1;
    load = 1'b1;
    bcd_in = 16'h8888;
    step();
    clear = 1'b0;
    load = 1'b0;
    run(3);

    do_load(16'h3210, 4'b0001);
    wait_idx(2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(N * RD);

    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      load = (r < 10);
      clear = (r >= 8 && r < 11);
      reset = (r == 11);
      case ($urandom_range(0, 3))
        0: bcd_in = 16'($urandom);
        1: bcd_in = 16'($urandom) & 16'h0FFF;
        2: bcd_in = 16'($urandom) & 16'h00FF;
        default: bcd_in = 16'($urandom) & 16'h000F;
      endcase
      dp_in = 4'($urandom);
      step();
    end
    load = 1'b0;
    clear = 1'b0;
    reset = 1'b0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
